stack_alu_sequencer: RTL and testbench
======================================

Name: stack_alu_sequencer

Overview:
- Initiator side of the stack ALU opcode/operand interface.
- Holds a small loadable program of (opcode, operand) words and issues it one word per cycle to a stack_base_alu instance.
- Tracks stack occupancy, captures popped results and stops on ALU overflow or stack misuse.
- Lets the stack ALU run from a stored program instead of hand-driven opcodes.

Parameters:
- N, 5, operand/result width; must match the ALU's data width.
- PROG_DEPTH, 16, program memory entries (power of two).
- STACK_DEPTH, 8, ALU stack capacity used for occupancy checking.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load_en  input  1  write one program word this cycle; ignored while busy.
- load_addr  input  log2(PROG_DEPTH)  program write address.
- load_word  input  3+N  {opcode[2:0], operand[N-1:0]}.
- prog_len  input  log2(PROG_DEPTH)+1  number of words to execute; sampled on start.
- start  input  1  begin execution at address 0; ignored while busy.
- busy  output  1  high from the cycle after start until DONE/ERROR.
- done  output  1  one-cycle pulse on normal completion.
- error  output  1  sticky; cleared by next accepted start or rst.
- err_code  output  2  01 overflow, 10 underflow, 11 stack full, 00 none.
- err_pc  output  log2(PROG_DEPTH)  address of the faulting word.
- alu_opcode  output  3  opcode to ALU.
- alu_input_data  output  N  operand to ALU.
- alu_output_data  input  N  ALU top-of-stack / pop result.
- alu_overflow  input  1  ALU signed overflow flag.
- result  output  N  last popped value.
- result_valid  output  1  one-cycle pulse when result updates.

Behaviour:
- Opcodes: 110 PUSH, 100 ADD, 101 MUL, 111 POP, 000 NOP (any 0xx is executed as NOP).
- ALU timing: the ALU samples opcode/data at edge k; output_data and overflow are valid during cycle k+1.
- Reset: all outputs 0, alu_opcode=NOP, state IDLE, stack count 0. Program memory is not cleared.
- Reset mid-run aborts immediately; the ALU is reset by the same rst.
- FSM IDLE: drive NOP. start with prog_len>0: latch len, pc=0, clear error/err_code/err_pc, go to ISSUE. start with prog_len=0: pulse done, stay IDLE.
- FSM ISSUE, per word at pc:
  - Legality check on the current count before driving. ADD/MUL need count>=2, else err 10. POP needs count>=1, else err 10. PUSH needs count<STACK_DEPTH, else err 11.
  - Illegal word: drive NOP, go to ERROR, err_pc=pc.
  - Legal word: drive opcode/operand for exactly one cycle.
  - Count update: PUSH +1, ADD/MUL -1, POP -1.
  - Arm check_ovf for ADD/MUL; arm capture for POP.
  - pc+1. If pc==len-1, go to DRAIN, else stay in ISSUE (back-to-back issue, no bubbles).
- Pipelined checks, evaluated in every state except IDLE:
  - check_ovf set and alu_overflow=1 in the following cycle: go to ERROR, err 01, err_pc = address of the ADD/MUL. Any word issued in that same cycle has already gone and is not recalled.
  - capture set: result=alu_output_data and result_valid pulses in the following cycle.
- FSM DRAIN: one cycle of NOP to resolve the final check, then pulse done and go to IDLE (or to ERROR if the final check fails).
- FSM ERROR: drive NOP, assert error, busy=0, return to IDLE the same cycle. error holds until the next start.
- Arithmetic: signed two's complement N-bit; the sequencer does no arithmetic beyond count and pc.
- load_en while busy: ignored.
- start while busy: ignored.
- load_en and start in the same cycle while idle: the write completes first, so the new word is executed.

Decomposition:
- stack_alu_pkg: opcode constants (OP_NOP, OP_ADD, OP_MUL, OP_PUSH, OP_POP), err_code constants, FSM state enum. Shared with stack_base_alu and benches.
- Sub-module: stack_alu_prog_mem (PROG_DEPTH x (3+N) register file; synchronous write, combinational read).

Test Plan:
- Program PUSH 01110, PUSH 11101, ADD, POP (len 4) -> ALU sees 110,110,100,111 in consecutive cycles; result=01011 with result_valid once; done pulse; error=0.
- PUSH 00010, PUSH 11011, MUL, POP -> result=10110 (-10); done.
- PUSH 01000, PUSH 01010, MUL, POP -> alu_overflow after MUL; error=1, err_code=01, err_pc=2; POP was already issued but no further words issue; no done.
- Program ADD first (empty stack) -> no ALU opcode other than NOP driven; err_code=10, err_pc=0.
- 9 PUSHes with STACK_DEPTH=8 -> err_code=11, err_pc=8. Then rst mid-run during a 16-word program -> all outputs 0 next cycle; a fresh start completes normally.
- start with prog_len=0 -> done pulse only. start asserted while busy -> ignored; pc sequence unaffected.

Source files
------------

// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack ALU and its program sequencer:
// opcode encodings, error codes and sequencer FSM states.
package stack_alu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OVF   = 2'b01;
    localparam logic [1:0] ERR_UNDER = 2'b10;
    localparam logic [1:0] ERR_FULL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_ERROR
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/stack_alu_prog_mem.sv
// Program store: register file with synchronous write and combinational read.
module stack_alu_prog_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_alu_sequencer.sv
// Issues a stored (opcode, operand) program to a stack ALU, one word per cycle,
// tracking stack occupancy and stopping on overflow or stack misuse.
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int unsigned N           = 5,
    parameter int unsigned PROG_DEPTH  = 16,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_en,
    input  logic [$clog2(PROG_DEPTH)-1:0] load_addr,
    input  logic [N+2:0]                  load_word,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [1:0]                    err_code,
    output logic [$clog2(PROG_DEPTH)-1:0] err_pc,
    output logic [2:0]                    alu_opcode,
    output logic [N-1:0]                  alu_input_data,
    input  logic [N-1:0]                  alu_output_data,
    input  logic                          alu_overflow,
    output logic [N-1:0]                  result,
    output logic                          result_valid
);

    localparam int unsigned PW = $clog2(PROG_DEPTH);
    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned WW = N + 3;

    state_t          state, state_nxt;
    logic [PW-1:0]   pc, pc_nxt, alu_pc, alu_pc_nxt, ovf_pc;
    logic [PW:0]     len, len_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            ovf_chk, cap_chk, ovf_hit;
    logic            busy_nxt, done_nxt, error_nxt;
    logic [1:0]      err_code_nxt;
    logic [PW-1:0]   err_pc_nxt;
    logic [2:0]      op_nxt;
    logic [N-1:0]    data_nxt;
    logic [WW-1:0]   word;
    logic [2:0]      word_op;
    logic [N-1:0]    word_data;

    stack_alu_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (PW),
        .WIDTH (WW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (load_en && !busy),
        .waddr (load_addr),
        .wdata (load_word),
        .raddr (pc),
        .rdata (word)
    );

    assign word_op   = word[N+2:N];
    assign word_data = word[N-1:0];
    assign ovf_hit   = ovf_chk && alu_overflow && (state == ST_ISSUE || state == ST_DRAIN);

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        len_nxt      = len;
        count_nxt    = count;
        alu_pc_nxt   = alu_pc;
        done_nxt     = 1'b0;
        error_nxt    = error;
        err_code_nxt = err_code;
        err_pc_nxt   = err_pc;
        op_nxt       = OP_NOP;
        data_nxt     = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (prog_len != '0) begin
                        len_nxt      = prog_len;
                        pc_nxt       = '0;
                        error_nxt    = 1'b0;
                        err_code_nxt = ERR_NONE;
                        err_pc_nxt   = '0;
                        state_nxt    = ST_ISSUE;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (ovf_hit) begin
                    state_nxt    = ST_ERROR;
                    error_nxt    = 1'b1;
                    err_code_nxt = ERR_OVF;
                    err_pc_nxt   = ovf_pc;
                end else if ((is_arith(word_op) && count < CW'(2)) ||
                             (word_op == OP_POP && count == '0)) begin
                    state_nxt    = ST_ERROR;
                    error_nxt    = 1'b1;
                    err_code_nxt = ERR_UNDER;
                    err_pc_nxt   = pc;
                end else if (word_op == OP_PUSH && count >= CW'(STACK_DEPTH)) begin
                    state_nxt    = ST_ERROR;
                    error_nxt    = 1'b1;
                    err_code_nxt = ERR_FULL;
                    err_pc_nxt   = pc;
                end else begin
                    // 0xx words pass as NOP and leave the stack untouched.
                    if (word_op[2]) begin
                        op_nxt     = word_op;
                        data_nxt   = word_data;
                        alu_pc_nxt = pc;
                        count_nxt  = (word_op == OP_PUSH) ? count + CW'(1) : count - CW'(1);
                    end
                    pc_nxt = pc + PW'(1);
                    if ({1'b0, pc} == len - (PW+1)'(1)) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Wait until the last word has been sampled and its check resolved.
                if (ovf_hit) begin
                    state_nxt    = ST_ERROR;
                    error_nxt    = 1'b1;
                    err_code_nxt = ERR_OVF;
                    err_pc_nxt   = ovf_pc;
                end else if (!alu_opcode[2]) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_ISSUE) || (state_nxt == ST_DRAIN);
    end

    // State and output registers; check flags trail the driven opcode by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            pc             <= '0;
            len            <= '0;
            count          <= '0;
            alu_pc         <= '0;
            ovf_pc         <= '0;
            ovf_chk        <= 1'b0;
            cap_chk        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= ERR_NONE;
            err_pc         <= '0;
            alu_opcode     <= OP_NOP;
            alu_input_data <= '0;
            result         <= '0;
            result_valid   <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            len            <= len_nxt;
            count          <= count_nxt;
            alu_pc         <= alu_pc_nxt;
            ovf_pc         <= alu_pc;
            ovf_chk        <= is_arith(alu_opcode);
            cap_chk        <= (alu_opcode == OP_POP);
            busy           <= busy_nxt;
            done           <= done_nxt;
            error          <= error_nxt;
            err_code       <= err_code_nxt;
            err_pc         <= err_pc_nxt;
            alu_opcode     <= op_nxt;
            alu_input_data <= data_nxt;
            result_valid   <= cap_chk && (state != ST_IDLE);
            if (cap_chk && state != ST_IDLE) begin
                result <= alu_output_data;
            end
        end
    end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer with a behavioural stack ALU attached.
module tb_stack_alu_sequencer;
    import stack_alu_pkg::*;

    localparam int unsigned N  = 5;
    localparam int unsigned SD = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_en = 1'b0;
    logic [3:0]   load_addr = '0;
    logic [7:0]   load_word = '0;
    logic [4:0]   prog_len = '0;
    logic         start = 1'b0;
    logic         busy, done, error, result_valid;
    logic [1:0]   err_code;
    logic [3:0]   err_pc;
    logic [2:0]   alu_opcode;
    logic [N-1:0] alu_input_data, alu_output_data, result;
    logic         alu_overflow;

    int checks = 0;
    int errors = 0;

    stack_alu_sequencer #(.N(N), .PROG_DEPTH(16), .STACK_DEPTH(SD)) dut (
        .clk             (clk),
        .rst             (rst),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_word       (load_word),
        .prog_len        (prog_len),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .err_code        (err_code),
        .err_pc          (err_pc),
        .alu_opcode      (alu_opcode),
        .alu_input_data  (alu_input_data),
        .alu_output_data (alu_output_data),
        .alu_overflow    (alu_overflow),
        .result          (result),
        .result_valid    (result_valid)
    );

    always #5 clk = ~clk;

    // Behavioural stack ALU: samples on the edge, output valid the next cycle.
    logic [N-1:0] stk [SD];
    int sp = 0;
    always @(posedge clk) begin
        int full;
        if (rst) begin
            sp = 0;
            alu_output_data <= '0;
            alu_overflow    <= 1'b0;
        end else begin
            alu_overflow <= 1'b0;
            case (alu_opcode)
                OP_PUSH: if (sp < SD) begin
                    stk[sp] = alu_input_data;
                    sp = sp + 1;
                    alu_output_data <= alu_input_data;
                end
                OP_ADD, OP_MUL: if (sp >= 2) begin
                    if (alu_opcode == OP_ADD)
                        full = 32'($signed(stk[sp-2])) + 32'($signed(stk[sp-1]));
                    else
                        full = 32'($signed(stk[sp-2])) * 32'($signed(stk[sp-1]));
                    sp = sp - 1;
                    stk[sp-1] = N'(full);
                    alu_output_data <= N'(full);
                    alu_overflow    <= (full > 15) || (full < -16);
                end
                OP_POP: if (sp >= 1) begin
                    sp = sp - 1;
                    alu_output_data <= stk[sp];
                end
                default: ;
            endcase
        end
    end

    // Observation of issued words and pulses.
    int         cyc = 0;
    int         done_cnt = 0;
    int         rv_cnt = 0;
    logic [2:0] iss_op[$];
    logic [4:0] iss_data[$];
    int         iss_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (result_valid) rv_cnt++;
        if (alu_opcode != OP_NOP) begin
            iss_op.push_back(alu_opcode);
            iss_data.push_back(alu_input_data);
            iss_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int addr, input logic [2:0] op, input logic [4:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 4'(addr);
        load_word = {op, data};
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic run_prog(input logic [4:0] len);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        prog_len = len;
        @(negedge clk);
        start    = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (done || error) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("run_timeout", 32'(0), 32'(1));
        repeat (3) @(negedge clk);
    endtask

    int b, d0, r0;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_flags", 32'({busy, done, error, result_valid}), 32'(0));
        check("rst_codes", 32'({err_code, err_pc}), 32'(0));
        check("rst_alu", 32'({alu_opcode, alu_input_data}), 32'(0));
        check("rst_result", 32'(result), 32'(0));

        // 14 + (-3) = 11
        load(0, OP_PUSH, 5'b01110); load(1, OP_PUSH, 5'b11101);
        load(2, OP_ADD, 5'b0);      load(3, OP_POP, 5'b0);
        b = iss_op.size(); d0 = done_cnt; r0 = rv_cnt;
        run_prog(5'd4);
        check("add_nissue", 32'(iss_op.size() - b), 32'(4));
        check("add_ops", 32'({iss_op[b], iss_op[b+1], iss_op[b+2], iss_op[b+3]}), 32'(12'b110_110_100_111));
        check("add_span", 32'(iss_cyc[b+3] - iss_cyc[b]), 32'(3));
        check("add_result", 32'(result), 32'(5'b01011));
        check("add_rv", 32'(rv_cnt - r0), 32'(1));
        check("add_done", 32'(done_cnt - d0), 32'(1));
        check("add_err", 32'({error, busy}), 32'(0));

        // 2 * (-5) = -10
        load(0, OP_PUSH, 5'b00010); load(1, OP_PUSH, 5'b11011);
        load(2, OP_MUL, 5'b0);
        d0 = done_cnt;
        run_prog(5'd4);
        check("mul_result", 32'(result), 32'(5'b10110));
        check("mul_done", 32'(done_cnt - d0), 32'(1));

        // 8 * 10 overflows; POP already issued
        load(0, OP_PUSH, 5'b01000); load(1, OP_PUSH, 5'b01010);
        b = iss_op.size(); d0 = done_cnt;
        run_prog(5'd4);
        check("ovf_error", 32'(error), 32'(1));
        check("ovf_code", 32'(err_code), 32'(ERR_OVF));
        check("ovf_pc", 32'(err_pc), 32'(2));
        check("ovf_nissue", 32'(iss_op.size() - b), 32'(4));
        check("ovf_last", 32'(iss_op[b+3]), 32'(OP_POP));
        check("ovf_nodone", 32'(done_cnt - d0), 32'(0));
        check("ovf_busy", 32'(busy), 32'(0));

        // ADD on empty stack
        load(0, OP_ADD, 5'b0);
        b = iss_op.size();
        run_prog(5'd2);
        check("und_nissue", 32'(iss_op.size() - b), 32'(0));
        check("und_code", 32'({error, err_code}), 32'({1'b1, ERR_UNDER}));
        check("und_pc", 32'(err_pc), 32'(0));

        // Nine pushes into an eight-deep stack
        for (int i = 0; i < 9; i++) load(i, OP_PUSH, 5'(i + 1));
        b = iss_op.size();
        run_prog(5'd9);
        check("full_nissue", 32'(iss_op.size() - b), 32'(8));
        check("full_code", 32'({error, err_code}), 32'({1'b1, ERR_FULL}));
        check("full_pc", 32'(err_pc), 32'(8));

        // Zero-length start
        d0 = done_cnt; b = iss_op.size();
        @(negedge clk); start = 1'b1; prog_len = 5'd0;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("len0_done", 32'(done_cnt - d0), 32'(1));
        check("len0_nissue", 32'(iss_op.size() - b), 32'(0));

        // Reset mid-run during a 16-word program
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) load(i, OP_PUSH, 5'(i + 1));
        for (int i = 8; i < 16; i++) load(i, OP_POP, 5'b0);
        @(negedge clk); start = 1'b1; prog_len = 5'd16;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_flags", 32'({busy, done, error, result_valid, err_code}), 32'(0));
        check("mid_rst_alu", 32'({alu_opcode, alu_input_data, result}), 32'(0));
        rst = 1'b0;

        // Fresh run, with an ignored start and load while busy
        b = iss_op.size(); d0 = done_cnt; r0 = rv_cnt;
        @(negedge clk); start = 1'b1; prog_len = 5'd16;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; prog_len = 5'd2; load_en = 1'b1; load_addr = 4'd12; load_word = {OP_PUSH, 5'd7};
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 80 && !seen; i++) begin
                if (done || error) seen = 1'b1;
                else @(negedge clk);
            end
            if (!seen) check("fresh_timeout", 32'(0), 32'(1));
        end
        repeat (3) @(negedge clk);
        check("fresh_nissue", 32'(iss_op.size() - b), 32'(16));
        check("fresh_seq", 32'({iss_data[b+2], iss_data[b+3], iss_data[b+4]}), 32'({5'd3, 5'd4, 5'd5}));
        check("fresh_op12", 32'(iss_op[b+12]), 32'(OP_POP));
        check("fresh_span", 32'(iss_cyc[b+15] - iss_cyc[b]), 32'(15));
        check("fresh_result", 32'(result), 32'(1));
        check("fresh_rv", 32'(rv_cnt - r0), 32'(8));
        check("fresh_done", 32'({done_cnt - d0, error}), 32'({32'(1), 1'b0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
